// File: rtl/btn_debounce.sv
// Front-panel button conditioner: synchroniser, debounce FSM, press/release strobes.
// Optional auto-repeat of press_o on held buttons when BTN_REPEAT_EN is defined.
module btn_debounce #(
  parameter int               N               = 8,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               SYNC_STAGES     = 2,
  parameter int               ACTIVE_LOW      = 0,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000,
  parameter logic [N-1:0]     REPEAT_MASK     = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         srst_i,
  input  logic [N-1:0] raw_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o
);

  localparam int   CW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 2) || (SYNC_STAGES < 2) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("btn_debounce: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_LO,
    ST_WHI,
    ST_HI,
    ST_WLO
  } st_t;

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    st_t                    r_st, w_st_n;
    logic [CW-1:0]          r_cnt, w_cnt_n;
    logic                   r_lvl, w_lvl_n;
    logic                   r_prs, w_prs_n;
    logic                   r_rel, w_rel_n;
    logic                   w_s;
`ifdef BTN_REPEAT_EN
    logic [RW-1:0]          r_rcnt, w_rcnt_n;
    logic                   r_rfirst, w_rfirst_n;
`endif

    assign w_s = r_sync[SYNC_STAGES-1] ^ INACT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sync <= {SYNC_STAGES{INACT}};
        r_st   <= ST_LO;
        r_cnt  <= '0;
        r_lvl  <= 1'b0;
        r_prs  <= 1'b0;
        r_rel  <= 1'b0;
`ifdef BTN_REPEAT_EN
        r_rcnt   <= '0;
        r_rfirst <= 1'b1;
`endif
      end else if (srst_i) begin
        r_sync <= {SYNC_STAGES{INACT}};
        r_st   <= ST_LO;
        r_cnt  <= '0;
        r_lvl  <= 1'b0;
        r_prs  <= 1'b0;
        r_rel  <= 1'b0;
`ifdef BTN_REPEAT_EN
        r_rcnt   <= '0;
        r_rfirst <= 1'b1;
`endif
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i[i]};
        r_st   <= w_st_n;
        r_cnt  <= w_cnt_n;
        r_lvl  <= w_lvl_n;
        r_prs  <= w_prs_n;
        r_rel  <= w_rel_n;
`ifdef BTN_REPEAT_EN
        r_rcnt   <= w_rcnt_n;
        r_rfirst <= w_rfirst_n;
`endif
      end
    end

    always_comb begin
      w_st_n  = r_st;
      w_cnt_n = r_cnt;
      w_lvl_n = r_lvl;
      w_prs_n = 1'b0;
      w_rel_n = 1'b0;
`ifdef BTN_REPEAT_EN
      w_rcnt_n   = r_rcnt;
      w_rfirst_n = r_rfirst;
`endif
      unique case (r_st)
        ST_LO: begin
          if (w_s) begin
            w_st_n  = ST_WHI;
            w_cnt_n = CW'(1);
          end
        end
        ST_WHI: begin
          if (!w_s) begin
            w_st_n  = ST_LO;
            w_cnt_n = '0;
          end else if (r_cnt == CMAX) begin
            w_st_n  = ST_HI;
            w_cnt_n = '0;
            w_lvl_n = 1'b1;
            w_prs_n = 1'b1;
`ifdef BTN_REPEAT_EN
            w_rcnt_n   = '0;
            w_rfirst_n = 1'b1;
`endif
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        ST_HI: begin
          if (!w_s) begin
            w_st_n  = ST_WLO;
            w_cnt_n = CW'(1);
          end
`ifdef BTN_REPEAT_EN
          // Repeat counter only ticks while the button stays accepted.
          else if (REPEAT_MASK[i]) begin
            if (r_rcnt == (r_rfirst ? RDLY : RPER)) begin
              w_prs_n    = 1'b1;
              w_rcnt_n   = '0;
              w_rfirst_n = 1'b0;
            end else begin
              w_rcnt_n = r_rcnt + RW'(1);
            end
          end
`endif
        end
        ST_WLO: begin
          if (w_s) begin
            w_st_n  = ST_HI;
            w_cnt_n = '0;
          end else if (r_cnt == CMAX) begin
            w_st_n  = ST_LO;
            w_cnt_n = '0;
            w_lvl_n = 1'b0;
            w_rel_n = 1'b1;
`ifdef BTN_REPEAT_EN
            w_rcnt_n   = '0;
            w_rfirst_n = 1'b1;
`endif
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        default: begin
          w_st_n  = ST_LO;
          w_cnt_n = '0;
        end
      endcase
    end

    assign level_o[i]   = r_lvl;
    assign press_o[i]   = r_prs;
    assign release_o[i] = r_rel;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (N=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Strobe events are queued at stimulus time and matched cycle-exactly.
module tb_btn_debounce;

  localparam int N   = 4;
  localparam int DC  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + DC;

  logic         clk;
  logic         rst_ni;
  logic         srst_i;
  logic [N-1:0] raw_i;
  logic [N-1:0] level_o;
  logic [N-1:0] press_o;
  logic [N-1:0] release_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           c;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] l;
  } ev_t;

  ev_t q[$];

  btn_debounce #(
    .N               (N),
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS),
    .ACTIVE_LOW      (0),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .REPEAT_MASK     (4'b0001)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .srst_i    (srst_i),
    .raw_i     (raw_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [N-1:0] p,
                      input logic [N-1:0] r, input logic [N-1:0] l);
    ev_t e;
    e.c = c;
    e.p = p;
    e.r = r;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    ev_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_strobe cyc=%0d got=none req p=%b r=%b",
                 q[0].c, q[0].p, q[0].r);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        total++;
        if ({press_o, release_o, level_o} !== {e.p, e.r, e.l}) begin
          bad++;
          $display("FAIL strobe cyc=%0d got p=%b r=%b l=%b req p=%b r=%b l=%b",
                   cyc, press_o, release_o, level_o, e.p, e.r, e.l);
        end
      end else if ((press_o | release_o) !== '0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d got p=%b r=%b req none",
                 cyc, press_o, release_o);
      end
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    srst_i = 1'b0;
    raw_i  = '0;
    #2;
    total++;
    if ({level_o, press_o, release_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b req=0",
               {level_o, press_o, release_o});
    end
    tick(3);
    rst_ni = 1'b1;
    tick(3);
    total++;
    if (level_o !== '0) begin
      bad++;
      $display("FAIL reset_level got=%b req=0000", level_o);
    end
  endtask

  task automatic test_clean_press;
    raw_i[0] = 1'b1;
    push(cyc + LAT, 4'b0001, 4'b0000, 4'b0001);
    tick(LAT - 1);
    total++;
    if (level_o !== 4'b0000) begin
      bad++;
      $display("FAIL early_level got=%b req=0000", level_o);
    end
    tick(3);
    total++;
    if (level_o !== 4'b0001) begin
      bad++;
      $display("FAIL press_level got=%b req=0001", level_o);
    end
    raw_i[0] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(LAT + 2);
  endtask

  task automatic test_bounce;
    raw_i[1] = 1'b1;
    tick(1);
    raw_i[1] = 1'b0;
    tick(1);
    raw_i[1] = 1'b1;
    tick(1);
    raw_i[1] = 1'b0;
    tick(1);
    raw_i[1] = 1'b1;
    push(cyc + LAT, 4'b0010, 4'b0000, 4'b0010);
    tick(LAT + 2);
    total++;
    if (level_o !== 4'b0010) begin
      bad++;
      $display("FAIL bounce_level got=%b req=0010", level_o);
    end
    raw_i[1] = 1'b0;
    push(cyc + LAT, 4'b0000, 4'b0010, 4'b0000);
    tick(LAT + 2);
  endtask

  task automatic test_glitch;
    raw_i[2] = 1'b1;
    tick(3);
    raw_i[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      total++;
      if (level_o !== 4'b0000) begin
        bad++;
        $display("FAIL glitch_level cyc=%0d got=%b req=0000", cyc, level_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    raw_i = 4'b1001;
    push(cyc + LAT, 4'b1001, 4'b0000, 4'b1001);
    tick(LAT + 2);
    raw_i = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b1001, 4'b0000);
    tick(LAT + 2);
    total++;
    if (level_o !== 4'b0000) begin
      bad++;
      $display("FAIL simul_level got=%b req=0000", level_o);
    end
  endtask

  task automatic test_reset_mid(input bit use_srst);
    raw_i[3] = 1'b1;
    push(cyc + LAT, 4'b1000, 4'b0000, 4'b1000);
    tick(LAT + 2);
    raw_i[0] = 1'b1;
    tick(4);
    total++;
    if (level_o !== 4'b1000) begin
      bad++;
      $display("FAIL premid_level got=%b req=1000", level_o);
    end
    if (use_srst) begin
      srst_i = 1'b1;
      tick(1);
    end else begin
      rst_ni = 1'b0;
      #1;
    end
    total++;
    if ({level_o, press_o, release_o} !== '0) begin
      bad++;
      $display("FAIL midreset_out srst=%0d got=%b req=0", use_srst,
               {level_o, press_o, release_o});
    end
    tick(2);
    rst_ni = 1'b1;
    srst_i = 1'b0;
    push(cyc + LAT, 4'b1001, 4'b0000, 4'b1001);
    tick(LAT + 2);
    raw_i = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b1001, 4'b0000);
    tick(LAT + 2);
  endtask

  task automatic test_repeat;
    int a;
    raw_i = 4'b0011;
    a = cyc + LAT;
    push(a, 4'b0011, 4'b0000, 4'b0011);
`ifdef BTN_REPEAT_EN
    push(a + 10, 4'b0001, 4'b0000, 4'b0011);
    push(a + 15, 4'b0001, 4'b0000, 4'b0011);
    push(a + 20, 4'b0001, 4'b0000, 4'b0011);
`endif
    tick(LAT + 21);
    total++;
    if (level_o !== 4'b0011) begin
      bad++;
      $display("FAIL repeat_level got=%b req=0011", level_o);
    end
    raw_i = 4'b0000;
    push(cyc + LAT, 4'b0000, 4'b0011, 4'b0000);
    tick(LAT + 2);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_repeat();
    tick(2);
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL leftover_event cyc=%0d got=none req p=%b r=%b",
               q[0].c, q[0].p, q[0].r);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the raw front-panel push-buttons before they reach the TOY system core (load, look, step, run, enter, stop, reset, debug).
- Per channel: synchronise the asynchronous input, debounce it with a stability counter, and produce a clean level plus one-cycle press/release strobes.
- Sits directly upstream of the system core's btn_*_i inputs, between the pad/panel GPIO and the core.

Parameters:
N, 8, number of button channels
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a change (10 ms at 50 MHz); must be >= 2
SYNC_STAGES, 2, synchroniser flop depth; must be >= 2
ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed (inverted after synchroniser)
REPEAT_DELAY, 25000000, cycles held before the first auto-repeat strobe (only with BTN_REPEAT_EN)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat strobes (only with BTN_REPEAT_EN)
REPEAT_MASK, '0 (N bits), channels for which auto-repeat is allowed

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
srst_i  input  1  synchronous clear, same effect as reset
raw_i  input  N  raw button pins, asynchronous
level_o  output  N  debounced level, 1 = pressed
press_o  output  N  one-cycle strobe on accepted press (and on auto-repeat)
release_o  output  N  one-cycle strobe on accepted release

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset (rst_ni low, or srst_i high at a clock edge):
  - sync flops load the inactive raw value (ACTIVE_LOW ? 1 : 0);
  - counters clear to 0;
  - level_o = 0, press_o = 0, release_o = 0.
- Synchroniser: SYNC_STAGES flops per channel. The sample s[i] is the last stage, XOR-inverted when ACTIVE_LOW = 1.
- Per-channel FSM with 4 states:
  - STABLE_LO (level 0, cnt 0): s = 1 -> WAIT_HI with cnt = 1.
  - WAIT_HI: s = 0 -> STABLE_LO with cnt = 0 (glitch rejected, no strobe). s = 1 and cnt = DEBOUNCE_CYCLES-1 -> STABLE_HI, level_o <= 1, press_o pulses for exactly the next cycle. Otherwise cnt++.
  - STABLE_HI: mirror of STABLE_LO, entering WAIT_LO.
  - WAIT_LO: mirror of WAIT_HI; on acceptance level_o <= 0 and release_o pulses.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps, because acceptance occurs at DEBOUNCE_CYCLES-1.
- Latency: raw_i edge held steady -> level_o and strobe change exactly SYNC_STAGES + DEBOUNCE_CYCLES clock edges later. Any pulse or gap shorter than DEBOUNCE_CYCLES cycles is ignored entirely.
- press_o and release_o for a channel are never high in the same cycle. level_o changes in the same cycle as its strobe goes high.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- Reset mid-bounce discards all progress. A button held through reset deassertion reports press_o after the full latency, measured from reset release.

Optional Feature:
BTN_REPEAT_EN.
- Defined: each channel with REPEAT_MASK[i] = 1 keeps a repeat counter while in STABLE_HI.
  - After REPEAT_DELAY cycles in STABLE_HI, press_o pulses once.
  - It then pulses every REPEAT_PERIOD cycles until the FSM leaves STABLE_HI; leaving clears the counter.
  - level_o is unaffected by repeats. WAIT_LO freezes the repeat counter; returning to STABLE_HI on a rejected glitch resumes it.
- Undefined: no repeat logic is synthesised; exactly one press_o per accepted press.

Test Plan:
- Clean press (N=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2): raw_i[0] 0->1 held -> level_o[0]=1 and press_o=4'b0001 for one cycle, 6 edges after the raw edge; all other outputs 0.
- Bounce: raw_i[1] toggles 1,0,1,0 each cycle, then holds 1 -> exactly one press_o[1] pulse, 6 edges after the final rising edge; no release_o.
- Glitch: raw_i[2] high for 3 cycles, then low -> level_o and strobes stay 0 throughout.
- Release plus simultaneity: channels 0 and 3 pressed, then both released on the same cycle -> release_o=4'b1001 in a single cycle, level_o returns to 0.
- Reset mid-count: assert rst_ni low 2 cycles into WAIT_HI with raw held 1 -> outputs 0 immediately (asynchronous); press_o fires 6 edges after rst_ni rises. Repeat the scenario with srst_i and check the same result.
- BTN_REPEAT_EN (REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_MASK=4'b0001): hold channel 0 -> press_o pulses at acceptance, then +10, +15, +20 cycles. Channel 1 held the same way gets one pulse only.
